// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//  Shared definitions for the run-time instruction memory loader: memory
//  geometry, loader state encoding, the NOP byte returned for out-of-range
//  fetches, and the bit positions of the instruction fields
//  {op[7:6], rs[5:4], rt[3:2], rd/imm[1:0]}.
package imem_loader_pkg;

    localparam int DEPTH  = 32;               // instruction bytes stored
    localparam int DATA_W = 8;                // instruction width
    localparam int ADDR_W = 8;                // PC / Read_Address width
    localparam int PTR_W  = $clog2(DEPTH);    // write pointer width
    localparam int CNT_W  = PTR_W + 1;        // word_count must reach DEPTH

    localparam logic [DATA_W-1:0] NOP = 8'h00;

    // Instruction field positions
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 2;
    localparam int RD_HI  = 1;
    localparam int RD_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/imem_loader_store.sv
// imem_store
//  DEPTH x DATA_W register array holding the program.
//  Ports:
//   clk    in  clock
//   clr    in  synchronous clear of every byte to 00 (highest priority)
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out combinational read data; a write to raddr is visible from
//              the cycle after the write edge
module imem_store
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//  Loads a program over a valid/ready byte stream into the instruction
//  memory and serves the CPU's combinational fetch port. The CPU is held in
//  reset while the memory is empty or being loaded.
//  Ports:
//   clk, reset     clock, synchronous active-high reset
//   load_start     pulse: start (or restart) a load at address 0
//   wr_valid/wr_data/wr_last/wr_ready   program byte stream
//   load_done      one-cycle pulse on entry into RUN
//   cpu_hold       1 while not in RUN
//   word_count     bytes accepted by the current/last load
//   Read_Address   fetch address, instruction = fetched byte (NOP if out of range)
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              load_done,
    output logic              cpu_hold,
    output logic [CNT_W-1:0]  word_count,
    input  logic [ADDR_W-1:0] Read_Address,
    output logic [DATA_W-1:0] instruction
);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               we;
    logic               fetch_hit;
    logic [DATA_W-1:0]  rd_byte;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        we      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (load_start) begin
                    // Restart wins over a byte offered in the same cycle.
                    ptr_d = '0;
                    cnt_d = '0;
                end else if (wr_valid) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    // Memory full is an implicit end of program.
                    if (wr_last || ptr_q == PTR_W'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    imem_store u_store (
        .clk   (clk),
        .clr   (reset),
        .we    (we),
        .waddr (ptr_q),
        .wdata (wr_data),
        .raddr (Read_Address[PTR_W-1:0]),
        .rdata (rd_byte)
    );

    assign fetch_hit   = Read_Address < ADDR_W'(DEPTH);
    assign instruction = fetch_hit ? rd_byte : NOP;
    assign wr_ready    = (state_q == ST_LOAD);
    assign cpu_hold    = (state_q != ST_RUN);
    assign load_done   = done_q;
    assign word_count  = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       wr_ready;
    logic       load_done;
    logic       cpu_hold;
    logic [5:0] word_count;
    logic [7:0] Read_Address;
    logic [7:0] instruction;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .load_done    (load_done),
        .cpu_hold     (cpu_hold),
        .word_count   (word_count),
        .Read_Address (Read_Address),
        .instruction  (instruction)
    );

    // Behavioural model: memory contents, whether a load is in progress,
    // whether a program has been loaded and the CPU may run, how many bytes
    // the load has taken so far, and a pending completion pulse.
    logic [7:0] m_mem [32];
    bit         m_loading;
    bit         m_running;
    int         m_count;
    bit         m_done;

    always @(posedge clk) begin
        if (reset) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_loading = 0;
            m_running = 0;
            m_count   = 0;
            m_done    = 0;
        end else begin
            m_done = 0;
            if (load_start) begin
                m_loading = 1;
                m_running = 0;
                m_count   = 0;
            end else if (m_loading && wr_valid) begin
                m_mem[m_count] = wr_data;
                m_count++;
                if (wr_last || m_count == 32) begin
                    m_loading = 0;
                    m_running = 1;
                    m_done    = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_ready",    int'(wr_ready),   int'(m_loading));
            chk("cpu_hold",    int'(cpu_hold),   int'(!m_running));
            chk("load_done",   int'(load_done),  int'(m_done));
            chk("word_count",  int'(word_count), m_count);
            chk("instruction", int'(instruction),
                Read_Address < 8'd32 ? int'(m_mem[Read_Address[4:0]]) : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    logic [7:0] t2_bytes [5] = '{8'h49, 8'hC1, 8'h18, 8'hA9, 8'h4D};

    initial begin
        reset = 1'b1; load_start = 1'b0; wr_valid = 1'b0;
        wr_data = 8'h00; wr_last = 1'b0; Read_Address = 8'h00;

        // 1: reset state, every address reads 00
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        chk("t1 hold",  int'(cpu_hold),   1);
        chk("t1 ready", int'(wr_ready),   0);
        chk("t1 count", int'(word_count), 0);
        for (int a = 0; a < 256; a++) begin
            Read_Address = 8'(a);
            #1;
            if (instruction !== 8'h00) chk("t1 instr", int'(instruction), 0);
            step();
        end
        chk("t1 instr 255", int'(instruction), 0);

        // 2: five-byte program terminated by wr_last
        start_load();
        for (int i = 0; i < 5; i++) send(t2_bytes[i], i == 4);
        chk("t2 done",  int'(load_done),  1);
        chk("t2 hold",  int'(cpu_hold),   0);
        chk("t2 count", int'(word_count), 5);
        step();
        chk("t2 done pulse", int'(load_done), 0);
        for (int a = 0; a < 5; a++) begin
            Read_Address = 8'(a);
            #1;
            chk("t2 readback", int'(instruction), int'(t2_bytes[a]));
            step();
        end

        // 3: full 32-byte load without wr_last, with valid gaps
        start_load();
        for (int i = 0; i < 32; i++) begin
            if (i % 3 == 1) step();
            send(8'(i * 7 + 3), 1'b0);
        end
        chk("t3 done",  int'(load_done),  1);
        chk("t3 count", int'(word_count), 32);
        chk("t3 ready", int'(wr_ready),   0);
        send(8'hEE, 1'b0);  // offered in RUN, must be ignored
        chk("t3 count hold", int'(word_count), 32);
        Read_Address = 8'd31; #1;
        chk("t3 addr31",  int'(instruction), 31 * 7 + 3);
        Read_Address = 8'd32; #1;
        chk("t3 addr32",  int'(instruction), 0);
        Read_Address = 8'd255; #1;
        chk("t3 addr255", int'(instruction), 0);
        step();

        // 4: restart coinciding with a valid byte
        start_load();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        load_start = 1'b1;
        send(8'h44, 1'b0);
        load_start = 1'b0;
        chk("t4 count restart", int'(word_count), 0);
        send(8'h55, 1'b0);
        chk("t4 count", int'(word_count), 1);
        Read_Address = 8'd0; #1;
        chk("t4 addr0", int'(instruction), 8'h55);
        Read_Address = 8'd1; #1;
        chk("t4 addr1", int'(instruction), 8'h22);
        Read_Address = 8'd3; #1;
        chk("t4 addr3", int'(instruction), 8'h44 == 8'h44 ? (3 * 7 + 3) : 0);
        send(8'h66, 1'b1);
        chk("t4 done", int'(load_done), 1);

        // 5: write-through timing on the fetched address
        start_load();
        send(8'hA0, 1'b0);
        send(8'hB1, 1'b0);
        Read_Address = 8'd2;
        wr_valid = 1'b1; wr_data = 8'hC2; wr_last = 1'b1;
        #1;
        chk("t5 old", int'(instruction), 8'h33);
        step();
        wr_valid = 1'b0; wr_last = 1'b0;
        chk("t5 new",  int'(instruction), 8'hC2);
        chk("t5 done", int'(load_done), 1);
        step();

        // 6: reset in the middle of a load
        start_load();
        send(8'h5A, 1'b0);
        send(8'hA5, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6 hold",  int'(cpu_hold),   1);
        chk("t6 ready", int'(wr_ready),   0);
        chk("t6 done",  int'(load_done),  0);
        chk("t6 count", int'(word_count), 0);
        step();
        chk("t6 done later", int'(load_done), 0);
        for (int a = 0; a < 5; a++) begin
            Read_Address = 8'(a);
            #1;
            chk("t6 cleared", int'(instruction), 0);
            step();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
